// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Two-requester round-robin arbiter and sequencer in front of a single-port
//   synchronous SRAM. One requester is granted at a time, its command is
//   latched, exactly one single-cycle memory access is issued, and the result
//   is returned as a one-cycle ready pulse (plus read data) to that requester.
//   A watchdog aborts the access with an error pulse if the memory never
//   answers within TIMEOUT cycles.
//
// Ports
//   clk_i, rst_n_i              clock (rising edge), async active-low reset
//   reqN_valid_i                request N valid, held until reqN_ready_o
//   reqN_wr_rd_i                request N direction: 1 = write, 0 = read
//   reqN_addr_i, reqN_wdata_i   request N address / write data
//   reqN_ready_o, reqN_err_o    request N completion / timeout pulses
//   reqN_rdata_o                request N read data, registered and held
//   mem_valid_o, mem_wr_rd_o,
//   mem_addr_o, mem_wdata_o     command to the memory
//   mem_ready_i, mem_rdata_i    response from the memory
//   busy_o                      high whenever the sequencer is not idle
module mem_rr_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned ADDR_SIZE = $clog2(DEPTH),
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,

    input  logic                 req0_valid_i,
    input  logic                 req0_wr_rd_i,
    input  logic [ADDR_SIZE-1:0] req0_addr_i,
    input  logic [WIDTH-1:0]     req0_wdata_i,
    output logic                 req0_ready_o,
    output logic                 req0_err_o,
    output logic [WIDTH-1:0]     req0_rdata_o,

    input  logic                 req1_valid_i,
    input  logic                 req1_wr_rd_i,
    input  logic [ADDR_SIZE-1:0] req1_addr_i,
    input  logic [WIDTH-1:0]     req1_wdata_i,
    output logic                 req1_ready_o,
    output logic                 req1_err_o,
    output logic [WIDTH-1:0]     req1_rdata_o,

    output logic                 mem_valid_o,
    output logic                 mem_wr_rd_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [WIDTH-1:0]     mem_wdata_o,
    input  logic                 mem_ready_i,
    input  logic [WIDTH-1:0]     mem_rdata_i,

    output logic                 busy_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    logic            last_grant;
    logic            grant_id;
    logic            pick;
    logic [WD_W-1:0] wdog;
    logic [WD_W-1:0] wdog_inc;

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // was not granted last time wins.
    always_comb begin
        pick = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            pick = ~last_grant;
        end else if (req1_valid_i) begin
            pick = 1'b1;
        end
    end

    assign wdog_inc = wdog + 1'b1;

    // The mem_* output registers double as the latched command: they are
    // loaded at grant and hold through WAIT and RESP.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            grant_id     <= 1'b0;
            wdog         <= '0;
            mem_valid_o  <= 1'b0;
            mem_wr_rd_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            req0_ready_o <= 1'b0;
            req0_err_o   <= 1'b0;
            req0_rdata_o <= '0;
            req1_ready_o <= 1'b0;
            req1_err_o   <= 1'b0;
            req1_rdata_o <= '0;
            busy_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_valid_i || req1_valid_i) begin
                        grant_id    <= pick;
                        last_grant  <= pick;
                        mem_valid_o <= 1'b1;
                        mem_wr_rd_o <= pick ? req1_wr_rd_i : req0_wr_rd_i;
                        mem_addr_o  <= pick ? req1_addr_i  : req0_addr_i;
                        mem_wdata_o <= pick ? req1_wdata_i : req0_wdata_i;
                        busy_o      <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_valid_o <= 1'b0;
                    wdog        <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    if (mem_ready_i) begin
                        if (!mem_wr_rd_o) begin
                            if (grant_id) begin
                                req1_rdata_o <= mem_rdata_i;
                            end else begin
                                req0_rdata_o <= mem_rdata_i;
                            end
                        end
                        req0_ready_o <= ~grant_id;
                        req1_ready_o <= grant_id;
                        state        <= RESP;
                    end else begin
                        wdog <= wdog_inc;
                        if (wdog_inc == WD_W'(TIMEOUT)) begin
                            req0_ready_o <= ~grant_id;
                            req1_ready_o <= grant_id;
                            req0_err_o   <= ~grant_id;
                            req1_err_o   <= grant_id;
                            state        <= RESP;
                        end
                    end
                end

                RESP: begin
                    req0_ready_o <= 1'b0;
                    req1_ready_o <= 1'b0;
                    req0_err_o   <= 1'b0;
                    req1_err_o   <= 1'b0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Bench for mem_rr_arbiter. Requester drivers replay per-requester command
//   queues; a transaction-level reference model decides grants from the
//   arbitration rules and pushes expected completions into a scoreboard; a
//   monitor pops and compares whenever the DUT presents a ready pulse. A
//   behavioural SRAM (registered ready/rdata) sits on the memory port.
module tb_mem_rr_arbiter;

    localparam int unsigned WIDTH     = 16;
    localparam int unsigned DEPTH     = 64;
    localparam int unsigned ADDR_SIZE = 6;
    localparam int unsigned TIMEOUT   = 8;

    typedef struct {
        logic                 wr;
        logic [ADDR_SIZE-1:0] addr;
        logic [WIDTH-1:0]     wdata;
    } cmd_t;

    typedef struct {
        int               id;
        logic             wr;
        logic [WIDTH-1:0] rdata;
        logic             err;
        int               rcyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic                 v [2] = '{1'b0, 1'b0};
    logic                 w [2] = '{1'b0, 1'b0};
    logic [ADDR_SIZE-1:0] a [2] = '{'0, '0};
    logic [WIDTH-1:0]     d [2] = '{'0, '0};

    logic                 r0_ready, r0_err, r1_ready, r1_err, busy;
    logic [WIDTH-1:0]     r0_rdata, r1_rdata;
    logic                 mem_valid, mem_wr;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WIDTH-1:0]     mem_wdata;
    logic                 m_ready = 1'b0;
    logic [WIDTH-1:0]     m_rdata = '0;

    // bench controls, written only by the stimulus process
    logic gap_en = 1'b0, mut_en = 1'b0, stray_en = 1'b0, stray_now = 1'b0, mem_dead = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_rr_arbiter #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_SIZE(ADDR_SIZE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req0_valid_i(v[0]), .req0_wr_rd_i(w[0]), .req0_addr_i(a[0]), .req0_wdata_i(d[0]),
        .req0_ready_o(r0_ready), .req0_err_o(r0_err), .req0_rdata_o(r0_rdata),
        .req1_valid_i(v[1]), .req1_wr_rd_i(w[1]), .req1_addr_i(a[1]), .req1_wdata_i(d[1]),
        .req1_ready_o(r1_ready), .req1_err_o(r1_err), .req1_rdata_o(r1_rdata),
        .mem_valid_o(mem_valid), .mem_wr_rd_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ready_i(m_ready), .mem_rdata_i(m_rdata),
        .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural SRAM ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    bit m_init = 1'b0;

    always @(posedge clk) begin : memory
        if (!m_init) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= WIDTH'(k * 'h1111);
            m_init <= 1'b1;
        end
        if (mem_valid && !mem_dead) begin
            m_ready <= 1'b1;
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            else        m_rdata <= mem[mem_addr];
        end else begin
            m_ready <= !mem_dead && (stray_now || (stray_en && $urandom_range(0, 5) == 0));
        end
    end

    // ---------------- requester drivers ----------------
    cmd_t cq [2][$];
    bit   mutd [2] = '{1'b0, 1'b0};

    always @(negedge clk) begin : driver
        cmd_t c;
        logic rdy;
        for (int i = 0; i < 2; i++) begin
            rdy = (i == 0) ? r0_ready : r1_ready;
            if (v[i] && rdy) begin
                mutd[i] = 1'b0;
                if (cq[i].size() != 0 && !gap_en) begin
                    c = cq[i].pop_front();
                    w[i] = c.wr; a[i] = c.addr; d[i] = c.wdata; v[i] = 1'b1;
                end else begin
                    v[i] = 1'b0;
                end
            end else if (v[i]) begin
                if (mut_en && !mutd[i]) begin
                    a[i] = a[i] ^ ADDR_SIZE'(4);
                    d[i] = ~d[i];
                    mutd[i] = 1'b1;
                end
            end else if (cq[i].size() != 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
                c = cq[i].pop_front();
                w[i] = c.wr; a[i] = c.addr; d[i] = c.wdata; v[i] = 1'b1;
            end
        end
    end

    // ---------------- reference model ----------------
    // Transaction level: the arbiter is free once the previous grant has
    // finished (latency to ready plus the response and return-to-idle
    // cycles); each grant produces one expected completion.
    int   cyc       = 0;
    int   free_at   = 0;
    int   issue_cyc = -1;
    logic last      = 1'b1;
    logic [WIDTH-1:0]     gold [DEPTH];
    bit                   g_init  = 1'b0;
    logic                 e_mwr   = 1'b0;
    logic [ADDR_SIZE-1:0] e_maddr = '0;
    logic [WIDTH-1:0]     e_mwd   = '0;
    exp_t sbq [$];

    always @(posedge clk) begin : model
        exp_t e;
        int   id;
        int   lat;
        cyc++;
        if (!g_init) begin
            for (int k = 0; k < DEPTH; k++) gold[k] = WIDTH'(k * 'h1111);
            g_init = 1'b1;
        end
        if (!rst_n) begin
            sbq.delete();
            free_at = 0; issue_cyc = -1; last = 1'b1;
            e_mwr = 1'b0; e_maddr = '0; e_mwd = '0;
        end else if (cyc >= free_at && (v[0] || v[1])) begin
            if (v[0] && v[1]) id = last ? 0 : 1;
            else              id = v[1] ? 1 : 0;
            last    = (id == 1);
            lat     = mem_dead ? TIMEOUT + 1 : 2;
            e.id    = id;
            e.wr    = w[id];
            e.err   = mem_dead;
            e.rcyc  = cyc + lat;
            e.rdata = '0;
            if (!mem_dead) begin
                if (w[id]) gold[a[id]] = d[id];
                else       e.rdata = gold[a[id]];
            end
            sbq.push_back(e);
            issue_cyc = cyc;
            free_at   = cyc + lat + 2;
            e_mwr = w[id]; e_maddr = a[id]; e_mwd = d[id];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    logic [WIDTH-1:0] exp_rd [2] = '{'0, '0};
    int glog [$];

    always @(negedge clk) begin : monitor
        exp_t e;
        logic x0, x1;
        if (!rst_n) begin
            exp_rd[0] = '0;
            exp_rd[1] = '0;
        end else begin
            x0 = 1'b0; x1 = 1'b0;
            if (r0_ready && r1_ready) chk("both_ready", 1, 0);
            if (r0_ready || r1_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_ready", {r1_ready, r0_ready}, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("grant_id", r1_ready ? 1 : 0, e.id);
                    chk("ready_cycle", cyc, e.rcyc);
                    x0 = (e.id == 0) && e.err;
                    x1 = (e.id == 1) && e.err;
                    if (!e.wr && !e.err) exp_rd[e.id] = e.rdata;
                    glog.push_back(e.id);
                end
            end else if (sbq.size() != 0 && cyc > sbq[0].rcyc) begin
                chk("missing_ready", cyc, sbq[0].rcyc);
                void'(sbq.pop_front());
            end
            chk("err0", r0_err, x0);
            chk("err1", r1_err, x1);
            chk("rdata0", r0_rdata, exp_rd[0]);
            chk("rdata1", r1_rdata, exp_rd[1]);
            chk("mem_valid", mem_valid, cyc == issue_cyc);
            chk("busy", busy, (issue_cyc >= 0) && (cyc >= issue_cyc) && (cyc < free_at - 1));
            chk("mem_wr", mem_wr, e_mwr);
            chk("mem_addr", mem_addr, e_maddr);
            chk("mem_wdata", mem_wdata, e_mwd);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int i, input logic wr, input int addr, input logic [WIDTH-1:0] wd);
        cmd_t c;
        c.wr = wr; c.addr = ADDR_SIZE'(addr); c.wdata = wd;
        cq[i].push_back(c);
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (n < maxc && !(cq[0].size() == 0 && cq[1].size() == 0 && !v[0] && !v[1]
                             && sbq.size() == 0 && cyc >= free_at)) begin
            @(negedge clk);
            n++;
        end
        if (n >= maxc) chk("idle_timeout", n, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_mem_valid();
        int n = 0;
        bit ok = 1'b0;
        while (n < 50 && !ok) begin
            @(negedge clk);
            if (mem_valid) ok = 1'b1;
            n++;
        end
        if (!ok) chk("mem_valid_timeout", n, 0);
    endtask

    task automatic ready_latency(input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(r0_ready || r1_ready) && n < lim);
    endtask

    task automatic check_log(input string name, input int base, input int n, input logic [7:0] pat);
        chk({name, "_count"}, glog.size() - base, n);
        for (int i = 0; i < n && base + i < glog.size(); i++) chk(name, glog[base + i], {31'd0, pat[i]});
    endtask

    task automatic check_zero(input string name);
        chk({name, "_r0"}, {r0_ready, r0_err, r1_ready, r1_err}, 0);
        chk({name, "_rdata"}, {r0_rdata, r1_rdata}, 0);
        chk({name, "_mem"}, {mem_valid, mem_wr, mem_addr}, 0);
        chk({name, "_mwd"}, mem_wdata, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int base;
        int lat;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");

        // both requesters valid at the first edge after reset
        push(0, 1'b0, 1, '0);
        push(1, 1'b0, 2, '0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        base = glog.size();
        wait_idle(100);
        check_log("tie_order", base, 2, 8'b10);
        chk("tie_rdata0", r0_rdata, 16'h1111);
        chk("tie_rdata1", r1_rdata, 16'h2222);

        // write then read back, with nominal latency
        push(0, 1'b1, 5, 16'hA5A5);
        push(0, 1'b0, 5, 16'h0000);
        wait_mem_valid();
        ready_latency(20, lat);
        chk("write_latency", lat, 2);
        wait_idle(100);
        chk("wr_rd_rdata0", r0_rdata, 16'hA5A5);

        // lone requester granted repeatedly
        base = glog.size();
        for (int k = 0; k < 3; k++) push(1, 1'($urandom_range(0, 1)), $urandom_range(16, 63), 16'($urandom));
        wait_idle(200);
        check_log("lone_req1", base, 3, 8'b111);

        // both continuously valid: strict alternation starting with req0
        base = glog.size();
        for (int k = 0; k < 3; k++) begin
            push(0, 1'($urandom_range(0, 1)), $urandom_range(16, 63), 16'($urandom));
            push(1, 1'($urandom_range(0, 1)), $urandom_range(16, 63), 16'($urandom));
        end
        wait_idle(200);
        check_log("alternate", base, 6, 8'b101010);

        // address changed after grant has no effect (3 -> 7)
        mut_en = 1'b1;
        push(0, 1'b0, 3, '0);
        wait_idle(100);
        mut_en = 1'b0;
        chk("latched_addr_rdata", r0_rdata, 16'h3333);

        // stray memory ready while idle produces nothing
        @(negedge clk) stray_now = 1'b1;
        @(negedge clk) stray_now = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_ready", {r0_ready, r1_ready, r0_err, r1_err}, 0);
        chk("stray_busy", busy, 0);

        // dead memory: watchdog abort
        mem_dead = 1'b1;
        push(0, 1'b0, 1, '0);
        wait_mem_valid();
        ready_latency(30, lat);
        chk("timeout_latency", lat, TIMEOUT + 1);
        chk("timeout_err", {r0_ready, r0_err}, 2'b11);
        wait_idle(100);
        mem_dead = 1'b0;
        chk("timeout_rdata", r0_rdata, 16'h3333);

        // async reset during WAIT
        push(0, 1'b0, 2, '0);
        wait_mem_valid();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_idle(100);
        chk("after_reset_rdata", r0_rdata, 16'h2222);

        // randomized traffic with gaps, command changes and stray readies
        gap_en = 1'b1; mut_en = 1'b1; stray_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            push(0, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 16'($urandom));
            push(1, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), 16'($urandom));
        end
        wait_idle(5000);
        gap_en = 1'b0; mut_en = 1'b0; stray_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
